mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 32-bit RISC-V five-stage pipeline. It consumes the EX/MEM register outputs and drives a ready-handshaked data-memory port. It handles byte, half and word alignment for loads and stores, and stalls the pipeline while memory is busy. It registers results into the MEM/WB boundary for write-back.

## Interface
- MAX_WAIT, 16, request cycles allowed before a bus-error timeout (must be ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- memread_MEM, memwrite_MEM  in  1  access type from EX/MEM
- memtoreg_MEM, regwrite_MEM  in  1  write-back controls from EX/MEM
- fun3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_MEM  in  32  byte address (also the ALU result forwarded to WB)
- writedata_MEM  in  32  store data, low-aligned
- rd_MEM  in  5  destination register
- dmem_req  out  1  access request (combinational)
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {alu_MEM[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read word, valid when dmem_ready=1
- dmem_ready  in  1  access completes at this rising edge
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- regwrite_WB, memtoreg_WB  out  1  MEM/WB controls
- rd_WB  out  5  MEM/WB destination register
- alu_WB  out  32  MEM/WB ALU result
- load_WB  out  32  extended load data
- misalign_WB, buserr_WB  out  1  one-cycle fault flags

## Operation
- Access is valid when memread_MEM or memwrite_MEM is 1. If both are 1, the access is a store.
- Misaligned access:
  - H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Also any fun3 of 011, 110 or 111 on a valid access.
  - Response: no dmem_req. MEM/WB receives regwrite_WB=0 and misalign_WB=1.
- Store lanes:
  - SB: wdata = 4 copies of byte[7:0]; be = 0001 << addr[1:0].
  - SH: wdata = 2 copies of half[15:0]; be = 0011 when addr[1]=0, 1100 when addr[1]=1.
  - SW: wdata passed through; be = 1111.
  - Loads drive be = 1111 and dmem_we = 0.
- Load extraction: select from dmem_rdata by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- FSM states are IDLE and WAIT. wait_cnt has width clog2(MAX_WAIT)+1.
- IDLE:
  - dmem_req = valid & aligned & !rst.
  - If dmem_ready=1: the access completes with no stall. Stay in IDLE.
  - If dmem_ready=0: stall_mem=1. Go to WAIT with wait_cnt=1.
- WAIT:
  - dmem_req=1. EX/MEM inputs are held stable by the stall.
  - dmem_ready=1: complete, go to IDLE, stall_mem=0 in this cycle.
  - dmem_ready=0 and wait_cnt=MAX_WAIT-1: timeout. stall_mem=0. MEM/WB receives buserr_WB=1 and regwrite_WB=0. Go to IDLE.
  - Otherwise: stall_mem=1 and wait_cnt increments.
- stall_mem = dmem_req & !dmem_ready & !timeout.
- MEM/WB register update at each rising edge:
  - rst: all WB outputs are 0.
  - stall_mem=1: load a bubble. regwrite_WB=0, memtoreg_WB=0, flags=0; rd_WB, alu_WB and load_WB are 0.
  - Otherwise: pass through the controls, rd and alu. On a completed load, load_WB = extracted data; otherwise load_WB = 0.
- A non-memory instruction passes to WB in 1 cycle with no handshake.

## Timing
- Reset values:
  - state=IDLE, wait_cnt=0.
  - All WB outputs are 0.
  - dmem_req=0 and stall_mem=0 while rst=1.
- rst asserted in WAIT: the FSM returns to IDLE at that edge. The request is dropped with no completion and no fault.
- Latency: a zero-wait access reaches WB 1 edge after EX/MEM presents it. Each wait cycle adds 1.
- Request duration: dmem_req stays high for at most MAX_WAIT cycles; stall_mem stays high for at most MAX_WAIT-1 cycles.
- Back-to-back accesses: after WAIT completes, the next EX/MEM instruction is handled in IDLE on the very next cycle. No dead cycle.
- Stability: dmem_addr, dmem_wdata, dmem_be and dmem_we are stable throughout a request.
- dmem_ready outside a request is ignored.

## Test plan
- SB with alu_MEM=0x1003 and writedata=0xAABBCCDD, ready tied high → dmem_addr=0x1000, be=1000, wdata=0xDDDDDDDD, stall_mem never high.
- LB at addr 0x2001 with rdata=0x0000_8000 → load_WB=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x2002 with rdata=0xBEEF0000 → 0x0000BEEF.
- LW at 0x3000 with ready delayed 3 cycles → stall_mem high for 3 cycles. WB bubbles (regwrite_WB=0) during those cycles. On the edge after ready: load_WB = rdata and regwrite_WB=1.
- With MAX_WAIT=4 and ready stuck low on SW → dmem_req high for 4 cycles and stall_mem high for 3. Then buserr_WB=1 and regwrite_WB=0 for exactly one cycle.
- LW at 0x4002 → dmem_req never asserted, misalign_WB=1, regwrite_WB=0. The next instruction proceeds with no stall.
- rst pulsed during cycle 2 of a WAIT → dmem_req=0 and stall_mem=0 immediately. All WB outputs are 0 after the edge and the FSM is in IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 memory-access stage with ready-handshaked data port and MEM/WB register
//
// Consumes EX/MEM outputs, aligns byte/half/word stores and loads, stalls the
// upstream pipeline while the data memory is busy, times out stuck requests,
// and registers results into MEM/WB.
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   memread_MEM, memwrite_MEM             access type (both set = store)
//   memtoreg_MEM, regwrite_MEM            write-back controls
//   fun3_MEM                              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_MEM                               byte address / ALU result
//   writedata_MEM                         low-aligned store data
//   rd_MEM                                destination register
//   dmem_req/we/addr/wdata/be             data-memory request side
//   dmem_rdata, dmem_ready                data-memory response side
//   stall_mem                             freeze PC, IF/ID, ID/EX, EX/MEM
//   regwrite_WB, memtoreg_WB, rd_WB,
//   alu_WB, load_WB                       MEM/WB register
//   misalign_WB, buserr_WB                one-cycle fault flags
module mem_access_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread_MEM,
    input  logic        memwrite_MEM,
    input  logic        memtoreg_MEM,
    input  logic        regwrite_MEM,
    input  logic [2:0]  fun3_MEM,
    input  logic [31:0] alu_MEM,
    input  logic [31:0] writedata_MEM,
    input  logic [4:0]  rd_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_mem,
    output logic        regwrite_WB,
    output logic        memtoreg_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] alu_WB,
    output logic [31:0] load_WB,
    output logic        misalign_WB,
    output logic        buserr_WB
);

    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next;

    logic        valid;
    logic        misaligned;
    logic        timeout;
    logic        complete;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign valid = memread_MEM | memwrite_MEM;

    always_comb begin
        misaligned = 1'b0;
        case (fun3_MEM)
            3'b001, 3'b101: misaligned = alu_MEM[0];
            3'b010:         misaligned = (alu_MEM[1:0] != 2'b00);
            3'b011, 3'b110, 3'b111: misaligned = 1'b1;
            default:        misaligned = 1'b0;
        endcase
        misaligned = misaligned & valid;
    end

    // A request in WAIT is held regardless of inputs: the stall freezes EX/MEM.
    assign timeout   = (state == S_WAIT) && !dmem_ready && (wait_cnt == LAST_WAIT);
    assign dmem_req  = !rst && ((state == S_WAIT) || (valid && !misaligned));
    assign stall_mem = dmem_req && !dmem_ready && !timeout;
    assign complete  = dmem_req && dmem_ready;

    assign dmem_we   = memwrite_MEM;
    assign dmem_addr = {alu_MEM[31:2], 2'b00};

    always_comb begin
        dmem_wdata = writedata_MEM;
        dmem_be    = 4'b1111;
        if (memwrite_MEM) begin
            case (fun3_MEM[1:0])
                2'b00: begin
                    dmem_wdata = {4{writedata_MEM[7:0]}};
                    dmem_be    = 4'b0001 << alu_MEM[1:0];
                end
                2'b01: begin
                    dmem_wdata = {2{writedata_MEM[15:0]}};
                    dmem_be    = alu_MEM[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    dmem_wdata = writedata_MEM;
                    dmem_be    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        case (alu_MEM[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = alu_MEM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (fun3_MEM)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = S_IDLE;
        wait_cnt_next = '0;
        case (state)
            S_IDLE: begin
                if (stall_mem) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = CW'(1);
                end
            end
            S_WAIT: begin
                if (stall_mem) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = wait_cnt + CW'(1);
                end
            end
            default: begin
                state_next    = S_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || stall_mem) begin
            regwrite_WB <= 1'b0;
            memtoreg_WB <= 1'b0;
            rd_WB       <= '0;
            alu_WB      <= '0;
            load_WB     <= '0;
            misalign_WB <= 1'b0;
            buserr_WB   <= 1'b0;
        end else begin
            regwrite_WB <= regwrite_MEM && !misaligned && !timeout;
            memtoreg_WB <= memtoreg_MEM;
            rd_WB       <= rd_MEM;
            alu_WB      <= alu_MEM;
            load_WB     <= (complete && !memwrite_MEM) ? load_ext : 32'd0;
            misalign_WB <= misaligned;
            buserr_WB   <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread_MEM, memwrite_MEM, memtoreg_MEM, regwrite_MEM;
    logic [2:0]  fun3_MEM;
    logic [31:0] alu_MEM, writedata_MEM;
    logic [4:0]  rd_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall_mem;
    logic        regwrite_WB, memtoreg_WB;
    logic [4:0]  rd_WB;
    logic [31:0] alu_WB, load_WB;
    logic        misalign_WB, buserr_WB;

    int checks = 0;
    int errors = 0;
    int req_n, stall_n, berr_n;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
        .memtoreg_MEM(memtoreg_MEM), .regwrite_MEM(regwrite_MEM),
        .fun3_MEM(fun3_MEM), .alu_MEM(alu_MEM), .writedata_MEM(writedata_MEM),
        .rd_MEM(rd_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall_mem(stall_mem),
        .regwrite_WB(regwrite_WB), .memtoreg_WB(memtoreg_WB), .rd_WB(rd_WB),
        .alu_WB(alu_WB), .load_WB(load_WB),
        .misalign_WB(misalign_WB), .buserr_WB(buserr_WB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        memread_MEM   = 1'b0;
        memwrite_MEM  = 1'b0;
        memtoreg_MEM  = 1'b0;
        regwrite_MEM  = 1'b0;
        fun3_MEM      = 3'b000;
        alu_MEM       = 32'd0;
        writedata_MEM = 32'd0;
        rd_MEM        = 5'd0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        nop();
        memread_MEM  = 1'b1;
        memtoreg_MEM = 1'b1;
        regwrite_MEM = 1'b1;
        fun3_MEM     = f3;
        alu_MEM      = addr;
        rd_MEM       = rd;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        nop();
        memwrite_MEM  = 1'b1;
        fun3_MEM      = f3;
        alu_MEM       = addr;
        writedata_MEM = data;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        load(f3, addr, 5'd5);
        dmem_rdata = rdata;
        dmem_ready = 1'b1;
        #1;
        check({tag, "_stall"}, 32'(stall_mem), 32'd0);
        step();
        check({tag, "_load"}, load_WB, exp);
    endtask

    initial begin
        rst = 1'b1;
        dmem_rdata = 32'd0;
        dmem_ready = 1'b0;
        load(3'b010, 32'h0000_3000, 5'd3);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall_mem), 32'd0);
        step();
        step();
        check("rst_regwrite", 32'(regwrite_WB), 32'd0);
        check("rst_alu", alu_WB, 32'd0);
        check("rst_rd", 32'(rd_WB), 32'd0);
        rst = 1'b0;

        // SB to 0x1003, ready tied high
        store(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        dmem_ready = 1'b1;
        #1;
        check("sb_req", 32'(dmem_req), 32'd1);
        check("sb_we", 32'(dmem_we), 32'd1);
        check("sb_addr", dmem_addr, 32'h0000_1000);
        check("sb_be", 32'(dmem_be), 32'h8);
        check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        check("sb_stall", 32'(stall_mem), 32'd0);
        step();
        check("sb_alu_wb", alu_WB, 32'h0000_1003);
        check("sb_load_wb", load_WB, 32'd0);

        // SH upper half
        store(3'b001, 32'h0000_1002, 32'h1234_5678);
        #1;
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'h5678_5678);
        step();

        // load extraction
        do_load("lb", 3'b000, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
        check("lb_regwrite", 32'(regwrite_WB), 32'd1);
        check("lb_rd", 32'(rd_WB), 32'd5);
        check("lb_memtoreg", 32'(memtoreg_WB), 32'd1);
        do_load("lbu", 3'b100, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
        do_load("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_0000, 32'h0000_BEEF);
        do_load("lh", 3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lw", 3'b010, 32'h0000_2004, 32'h0102_0304, 32'h0102_0304);

        // LW with ready delayed 3 cycles
        load(3'b010, 32'h0000_3000, 5'd7);
        dmem_ready = 1'b0;
        dmem_rdata = 32'hDEAD_0000;
        #1;
        check("lw_be", 32'(dmem_be), 32'hF);
        check("lw_we", 32'(dmem_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("lwd_stall", 32'(stall_mem), 32'd1);
            check("lwd_addr", dmem_addr, 32'h0000_3000);
            step();
            check("lwd_bubble", 32'(regwrite_WB), 32'd0);
            #1;
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234_5678;
        #1;
        check("lwd_ready_stall", 32'(stall_mem), 32'd0);
        check("lwd_ready_req", 32'(dmem_req), 32'd1);
        step();
        check("lwd_load", load_WB, 32'h1234_5678);
        check("lwd_regwrite", 32'(regwrite_WB), 32'd1);
        check("lwd_rd", 32'(rd_WB), 32'd7);
        // back-to-back, handled in IDLE immediately
        do_load("b2b", 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // SW with ready stuck low: timeout after MAX_WAIT=4 request cycles
        store(3'b010, 32'h0000_5000, 32'h1122_3344);
        regwrite_MEM = 1'b1;
        dmem_ready = 1'b0;
        req_n = 0;
        stall_n = 0;
        berr_n = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            req_n += int'(dmem_req);
            stall_n += int'(stall_mem);
            step();
            berr_n += int'(buserr_WB);
        end
        check("to_buserr", 32'(buserr_WB), 32'd1);
        check("to_regwrite", 32'(regwrite_WB), 32'd0);
        check("to_req_cycles", 32'(req_n), 32'd4);
        check("to_stall_cycles", 32'(stall_n), 32'd3);
        nop();
        #1;
        check("to_after_req", 32'(dmem_req), 32'd0);
        step();
        berr_n += int'(buserr_WB);
        check("to_buserr_pulses", 32'(berr_n), 32'd1);

        // misaligned LW then a plain ALU instruction
        load(3'b010, 32'h0000_4002, 5'd8);
        dmem_ready = 1'b1;
        #1;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_stall", 32'(stall_mem), 32'd0);
        step();
        check("mis_flag", 32'(misalign_WB), 32'd1);
        check("mis_regwrite", 32'(regwrite_WB), 32'd0);
        nop();
        regwrite_MEM = 1'b1;
        alu_MEM = 32'h0000_0077;
        rd_MEM = 5'd9;
        #1;
        check("alu_stall", 32'(stall_mem), 32'd0);
        step();
        check("alu_regwrite", 32'(regwrite_WB), 32'd1);
        check("alu_value", alu_WB, 32'h0000_0077);
        check("alu_misflag", 32'(misalign_WB), 32'd0);

        // illegal fun3 011 is treated as misaligned
        load(3'b011, 32'h0000_4000, 5'd4);
        #1;
        check("f3_req", 32'(dmem_req), 32'd0);
        step();
        check("f3_flag", 32'(misalign_WB), 32'd1);

        // reset during the second WAIT cycle
        load(3'b010, 32'h0000_6000, 5'd6);
        dmem_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rw_req", 32'(dmem_req), 32'd0);
        check("rw_stall", 32'(stall_mem), 32'd0);
        step();
        check("rw_regwrite", 32'(regwrite_WB), 32'd0);
        check("rw_alu", alu_WB, 32'd0);
        check("rw_load", load_WB, 32'd0);
        check("rw_flags", {30'd0, misalign_WB, buserr_WB}, 32'd0);
        rst = 1'b0;
        // in IDLE a misaligned access raises no request; in WAIT it would
        load(3'b010, 32'h0000_4002, 5'd2);
        #1;
        check("rw_idle_req", 32'(dmem_req), 32'd0);
        step();
        check("rw_idle_mis", 32'(misalign_WB), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
